// File: rtl/quant_requant_pipe.sv
// Three-stage per-channel requantizer: multiply, round/shift, offset/clamp; 3-cycle latency at 1 beat/clk.
// One global enable (!out_valid | out_ready) freezes every stage together, so in_ready is purely combinational.
module quant_requant_pipe #(
  parameter int ACC_W   = 15,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 4,
  parameter int ZP_W    = 4,
  parameter int OUT_W   = 4,
  parameter int NCH     = 4,
  parameter int CH_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [SCALE_W-1:0]  cfg_scale,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  input  logic [ZP_W-1:0]     cfg_zp,
  input  logic                relu_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACC_W-1:0]    in_acc,
  input  logic [CH_W-1:0]     in_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_q,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_sat,
  output logic                out_err,
  output logic [15:0]         sat_cnt
);

  localparam int PW = ACC_W + SCALE_W + 1;
  localparam int RW = PW + 1;
  localparam int VW = RW + 1;

  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic [ZP_W-1:0]    zp;
    logic [CH_W-1:0]    ch;
    logic               err;
  } meta1_t;

  typedef struct packed {
    logic [ZP_W-1:0] zp;
    logic [CH_W-1:0] ch;
    logic            err;
  } meta2_t;

  logic [SCALE_W-1:0] r_scale [NCH];
  logic [SHIFT_W-1:0] r_shift [NCH];
  logic [ZP_W-1:0]    r_zp    [NCH];

  logic               w_en;
  logic [SCALE_W-1:0] w_scale;
  logic [SHIFT_W-1:0] w_shift;
  logic [ZP_W-1:0]    w_zp;
  logic               w_err;
  logic signed [PW-1:0] w_prod;

  logic                 r1_vld;
  logic signed [PW-1:0] r1_prod;
  meta1_t               r1_meta;

  logic signed [RW-1:0] w_p2;
  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_r2;

  logic                 r2_vld;
  logic signed [RW-1:0] r2_val;
  meta2_t               r2_meta;

  logic signed [VW-1:0] w_zp_ext;
  logic signed [VW-1:0] w_v;
  logic signed [VW-1:0] w_lo;
  logic signed [VW-1:0] w_hi;
  logic [OUT_W-1:0]     w_q;
  logic                 w_sat;

  logic                 r_out_vld;
  logic [OUT_W-1:0]     r_out_q;
  logic [CH_W-1:0]      r_out_ch;
  logic                 r_out_sat;
  logic                 r_out_err;
  logic [15:0]          r_sat_cnt;

  assign w_en     = !r_out_vld || out_ready;
  assign in_ready = w_en;

  // Writes to channels outside the table match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_scale[k] <= SCALE_W'(1);
        r_shift[k] <= '0;
        r_zp[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cfg_we && (cfg_ch == CH_W'(k))) begin
          r_scale[k] <= cfg_scale;
          r_shift[k] <= cfg_shift;
          r_zp[k]    <= cfg_zp;
        end
      end
    end
  end

  always_comb begin
    w_scale = '0;
    w_shift = '0;
    w_zp    = '0;
    w_err   = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (in_ch == CH_W'(k)) begin
        w_scale = r_scale[k];
        w_shift = r_shift[k];
        w_zp    = r_zp[k];
        w_err   = 1'b0;
      end
    end
  end

  // Zero-extending the scale keeps it non-negative in the signed product.
  assign w_prod = PW'($signed(in_acc)) * $signed({{(PW-SCALE_W){1'b0}}, w_scale});

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_prod <= '0;
      r1_meta <= '0;
    end else if (w_en) begin
      r1_vld <= in_valid;
      if (in_valid) begin
        r1_prod       <= w_prod;
        r1_meta.shift <= w_shift;
        r1_meta.zp    <= w_zp;
        r1_meta.ch    <= in_ch;
        r1_meta.err   <= w_err;
      end
    end
  end

  assign w_p2 = RW'(r1_prod);

  always_comb begin
    w_rnd = '0;
    if (r1_meta.shift != '0) begin
      w_rnd = RW'(1) << (r1_meta.shift - SHIFT_W'(1));
    end
  end

  assign w_r2 = (w_p2 + w_rnd) >>> r1_meta.shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_vld  <= 1'b0;
      r2_val  <= '0;
      r2_meta <= '0;
    end else if (w_en) begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_val     <= w_r2;
        r2_meta.zp <= r1_meta.zp;
        r2_meta.ch <= r1_meta.ch;
        r2_meta.err <= r1_meta.err;
      end
    end
  end

  assign w_zp_ext = $signed({{(VW-ZP_W){1'b0}}, r2_meta.zp});
  assign w_v      = VW'(r2_val) + w_zp_ext;
  assign w_lo     = relu_en ? w_zp_ext : '0;
  assign w_hi     = $signed({{(VW-OUT_W){1'b0}}, {OUT_W{1'b1}}});

  // Raising the floor to zp under ReLU is a clamp but not a saturation event.
  always_comb begin
    w_q   = w_v[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_v[VW-1]) begin
      w_q   = w_lo[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_v > w_hi) begin
      w_q   = w_hi[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_v < w_lo) begin
      w_q   = w_lo[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_q   <= '0;
      r_out_ch  <= '0;
      r_out_sat <= 1'b0;
      r_out_err <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (w_en) begin
        r_out_vld <= r2_vld;
        if (r2_vld) begin
          r_out_q   <= w_q;
          r_out_ch  <= r2_meta.ch;
          r_out_sat <= w_sat;
          r_out_err <= r2_meta.err;
        end
      end
      if (r_out_vld && out_ready && r_out_sat && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_q     = r_out_q;
  assign out_ch    = r_out_ch;
  assign out_sat   = r_out_sat;
  assign out_err   = r_out_err;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: doc/quant_requant_pipe.md
Name: quant_requant_pipe

Overview:
- Pipelined, multi-channel requantizer. Converts signed conv accumulator results to unsigned OUT_W-bit activations: q = clamp(round(acc*scale >> shift) + zero_point).
- Successor to the single-channel combinational quantizer. Adds per-channel scale/shift/zero-point tables, round-half-up, optional ReLU clamp, valid/ready backpressure and a saturation counter.
- Sits between the MAC accumulator output and the activation line buffer.

Parameters:
- ACC_W, 15, signed accumulator width.
- SCALE_W, 16, unsigned multiplier width.
- SHIFT_W, 4, right-shift amount width.
- ZP_W, 4, unsigned zero-point width (ZP_W <= OUT_W).
- OUT_W, 4, unsigned output width.
- NCH, 4, number of channels in the config table.
- CH_W, 2, channel index width (2^CH_W >= NCH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  channel to write.
- cfg_scale  in  SCALE_W  scale value.
- cfg_shift  in  SHIFT_W  shift value.
- cfg_zp  in  ZP_W  zero-point value.
- relu_en  in  1  raises the lower clamp bound to zero_point.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_acc  in  ACC_W  signed accumulator value.
- in_ch  in  CH_W  channel of the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_q  out  OUT_W  quantized result.
- out_ch  out  CH_W  channel tag, carried through.
- out_sat  out  1  result was range-clamped.
- out_err  out  1  in_ch was >= NCH.
- sat_cnt  out  16  saturating count of out_sat beats accepted downstream.

Behaviour:
- Reset (clk edge with rst=1):
  - Every table entry: scale=1, shift=0, zp=0.
  - All stage valids = 0; out_valid = 0; out_q, out_ch, out_sat, out_err = 0; sat_cnt = 0.
  - rst mid-stream discards all in-flight beats. No output is produced for them.
- Global enable: en = !out_valid | out_ready. in_ready = en, combinational.
  - Input accept = in_valid & in_ready.
  - All stages advance only when en=1. When en=0, every stage holds.
- Latency: exactly 3 cycles from accept to out_valid when out_ready is held at 1. Throughput is 1 beat/clk.
- S1 (multiply):
  - Register prod = signed(in_acc) * unsigned(in_scale), width ACC_W+SCALE_W+1, sign-correct.
  - Register the shift, zp and ch of the beat, using the table entry for in_ch.
  - If in_ch >= NCH: use scale=0, shift=0, zp=0 and set the err tag.
- S2 (round + shift):
  - shift=0: r = prod.
  - shift>0: r = (prod + (1 << (shift-1))) >>> shift, arithmetic. This is round-half-up; -1.5 becomes -1.
  - Internal width must not overflow; use one extra bit.
- S3 (offset + clamp):
  - v = r + zp, signed.
  - lo = relu_en ? zp : 0; hi = 2^OUT_W - 1.
  - out_q = clamp(v, lo, hi).
  - out_sat = 1 only when v < 0 or v > hi. The ReLU clamp alone does not set it.
  - relu_en is sampled at S3.
- Output holds stable while out_valid & !out_ready.
- Config writes:
  - A write lands at the clk edge.
  - A beat accepted in the same cycle as a write to its channel uses the OLD value.
  - Writes with cfg_ch >= NCH are ignored.
  - Writes proceed regardless of stall.
- sat_cnt increments on out_valid & out_ready & out_sat and saturates at 0xFFFF (no wrap).
- in_valid=0 inserts bubbles. Bubbles propagate and are not collapsed.

Test Plan:
- Saturation: reset, cfg ch0 scale=2 shift=0 zp=1, send acc=3071 -> 3 clk later out_q=15, out_sat=1, sat_cnt=1.
- Rounding: ch1 scale=3 shift=2 zp=1, acc=5 -> out_q=5. Ch2 scale=1 shift=2 zp=3: acc=-6 -> out_q=2; acc=-7 -> out_q=1; acc=6 -> out_q=5.
- ReLU and negative clamp: ch2 zp=3, acc=-40, relu_en=0 -> out_q=0, out_sat=1. Same beat with relu_en=1 -> out_q=3, out_sat=1.
- Backpressure:
  - Stream 8 beats on ch0..3 round-robin, out_ready toggled 1,0,0,1...
  - Required: in_ready == (!out_valid | out_ready); no loss, duplication or reordering; out_ch matches input order; out_q held while stalled.
- Config hazard: write ch1 scale=4 in the same cycle a ch1 beat (acc=1, shift=0, zp=0, old scale=3) is accepted -> out_q=3. The next ch1 beat with acc=1 -> out_q=4.
- Reset and error:
  - Assert rst for 1 clk with 3 beats in flight -> no out_valid for them; table back to scale=1.
  - Then in_ch=NCH (NCH non-power-of-2 build, e.g. NCH=3): out_err=1, out_q=0.
